// File: rtl/rgbw_pwm_pkg.sv
// Shared constants, state encoding and offset helper for the RGBW PWM stage.
package rgbw_pwm_pkg;

    localparam int unsigned DUTY_W     = 8;
    localparam int unsigned PWM_PERIOD = 255;
    localparam int unsigned NUM_CH     = 4;

    // Channel indices
    localparam int unsigned CH_R = 0;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 2;
    localparam int unsigned CH_W = 3;

    // Turn-on phase offsets in ticks when staggering is enabled
    localparam int unsigned OFF_R = 0;
    localparam int unsigned OFF_G = 64;
    localparam int unsigned OFF_B = 128;
    localparam int unsigned OFF_W = 192;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Phase offset of a channel; all zero when staggering is off
    function automatic int unsigned chan_offset(input int unsigned ch, input bit stagger);
        int unsigned off;
        off = OFF_R;
        if (stagger) begin
            case (ch)
                CH_G:    off = OFF_G;
                CH_B:    off = OFF_B;
                CH_W:    off = OFF_W;
                default: off = OFF_R;
            endcase
        end
        return off;
    endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: shadow duty register, offset-modulo position compare and
// registered pin.
//   clk, reset : clock, asynchronous active-low reset
//   load       : shadow load strobe (period boundary / enable edge)
//   active     : FSM is not idle
//   cnt        : shared period counter 0..PERIOD-1
//   duty       : live duty input, captured on load
//   pwm        : registered PWM pin
module pwm_channel_cmp
    import rgbw_pwm_pkg::*;
#(
    parameter int unsigned OFFSET = OFF_R,
    parameter int unsigned PERIOD = PWM_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              active,
    input  logic [DUTY_W-1:0] cnt,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    localparam int unsigned POS_W = DUTY_W + 1;

    logic [DUTY_W-1:0] duty_sh;
    logic [POS_W-1:0]  pos_raw;
    logic [POS_W-1:0]  pos;
    logic              on_c;

    // Position within the period shifted by the offset; 9-bit so cnt+offset never wraps
    always_comb begin
        pos_raw = POS_W'(cnt) + POS_W'(OFFSET);
        pos     = pos_raw;
        if (pos_raw >= POS_W'(PERIOD)) begin
            pos = pos_raw - POS_W'(PERIOD);
        end
        on_c = (pos < POS_W'(duty_sh));
    end

    // Shadow duty and registered pin; pin uses the shadow value from before a load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_sh <= '0;
            pwm     <= 1'b0;
        end else begin
            if (load) begin
                duty_sh <= duty;
            end
            pwm <= active && on_c;
        end
    end

endmodule

// File: rtl/rgbw_pwm_generator.sv
// Four-channel RGBW PWM generator with period-boundary shadow loading and
// optional turn-on phase stagger.
//   clk, reset        : clock, asynchronous active-low reset
//   enable            : level-sensitive run request
//   presc             : tick every presc+1 clocks (captured at period boundary)
//   red/green/blue/white_in  : duty inputs (captured at period boundary)
//   red/green/blue/white_pwm : registered PWM pins
//   period_start      : one-clock pulse after shadows are loaded
//   busy              : high while running or finishing the last period
module rgbw_pwm_generator
    import rgbw_pwm_pkg::*;
#(
    parameter bit          STAGGER_EN = 1'b1,
    parameter int unsigned PERIOD     = PWM_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DUTY_W-1:0] presc,
    input  logic [DUTY_W-1:0] red_in,
    input  logic [DUTY_W-1:0] green_in,
    input  logic [DUTY_W-1:0] blue_in,
    input  logic [DUTY_W-1:0] white_in,
    output logic              red_pwm,
    output logic              green_pwm,
    output logic              blue_pwm,
    output logic              white_pwm,
    output logic              period_start,
    output logic              busy
);

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);

    state_t                        state;
    state_t                        state_nxt;
    logic [DUTY_W-1:0]             pcnt;
    logic [DUTY_W-1:0]             cnt;
    logic [DUTY_W-1:0]             presc_sh;
    logic                          tick;
    logic                          wrap;
    logic                          load;
    logic                          running;
    logic [NUM_CH-1:0][DUTY_W-1:0] duty_in;
    logic [NUM_CH-1:0]             pwm_q;

    assign duty_in[CH_R] = red_in;
    assign duty_in[CH_G] = green_in;
    assign duty_in[CH_B] = blue_in;
    assign duty_in[CH_W] = white_in;

    assign running = (state != IDLE);

    // Next state and shadow load strobe; the wrap tick decides between reload and stop
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        tick      = (pcnt == presc_sh);
        wrap      = tick && (cnt == CNT_LAST);
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN, STOPPING: begin
                if (wrap) begin
                    if (enable) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = enable ? RUN : STOPPING;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Prescaler, period counter and prescaler shadow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt     <= '0;
            cnt      <= '0;
            presc_sh <= '0;
        end else if (load) begin
            pcnt     <= '0;
            cnt      <= '0;
            presc_sh <= presc;
        end else if (!running) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            cnt  <= wrap ? '0 : cnt + DUTY_W'(1);
        end else begin
            pcnt <= pcnt + DUTY_W'(1);
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            period_start <= load;
            busy         <= (state_nxt != IDLE);
        end
    end

    // Per-channel compare with its phase offset
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pwm_channel_cmp #(
            .OFFSET (chan_offset(ch, STAGGER_EN)),
            .PERIOD (PERIOD)
        ) u_cmp (
            .clk    (clk),
            .reset  (reset),
            .load   (load),
            .active (running),
            .cnt    (cnt),
            .duty   (duty_in[ch]),
            .pwm    (pwm_q[ch])
        );
    end

    assign red_pwm   = pwm_q[CH_R];
    assign green_pwm = pwm_q[CH_G];
    assign blue_pwm  = pwm_q[CH_B];
    assign white_pwm = pwm_q[CH_W];

endmodule

// File: tb/tb_rgbw_pwm_generator.sv
// Bench for rgbw_pwm_generator: one staggered and one unstaggered instance
// against a period-time model, plus directed literal measurements.
module tb_rgbw_pwm_generator;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       enable   = 1'b0;
    logic [7:0] presc    = 8'd0;
    logic [7:0] red_in   = 8'd0;
    logic [7:0] green_in = 8'd0;
    logic [7:0] blue_in  = 8'd0;
    logic [7:0] white_in = 8'd0;

    logic r0, g0, b0, w0, ps0, busy0;
    logic r1, g1, b1, w1, ps1, busy1;
    logic [3:0] pin0, pin1;
    assign pin0 = {w0, b0, g0, r0};
    assign pin1 = {w1, b1, g1, r1};

    int checks = 0;
    int errors = 0;

    initial forever #5 clk = ~clk;

    rgbw_pwm_generator #(.STAGGER_EN(1'b0), .PERIOD(255)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .presc(presc),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .white_in(white_in),
        .red_pwm(r0), .green_pwm(g0), .blue_pwm(b0), .white_pwm(w0),
        .period_start(ps0), .busy(busy0)
    );

    rgbw_pwm_generator #(.STAGGER_EN(1'b1), .PERIOD(255)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .presc(presc),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .white_in(white_in),
        .red_pwm(r1), .green_pwm(g1), .blue_pwm(b1), .white_pwm(w1),
        .period_start(ps1), .busy(busy1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: time t within the current period; cnt = t/(presc+1); pin = active && ((cnt+off)%255 < duty)
    bit         m_act = 1'b0;
    int         m_t   = 0;
    int         m_p   = 0;
    int         m_duty [4];
    logic [3:0] e_pin0 = '0;
    logic [3:0] e_pin1 = '0;
    logic       e_ps   = 1'b0;
    logic       e_busy = 1'b0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_act  = 1'b0;
            m_t    = 0;
            m_p    = 0;
            for (int k = 0; k < 4; k++) m_duty[k] = 0;
            e_pin0 = '0;
            e_pin1 = '0;
            e_ps   = 1'b0;
            e_busy = 1'b0;
        end else begin
            int c;
            bit do_load;
            c = m_t / (m_p + 1);
            for (int k = 0; k < 4; k++) begin
                e_pin0[k] = m_act && ((c % 255) < m_duty[k]);
                e_pin1[k] = m_act && (((c + 64 * k) % 255) < m_duty[k]);
            end
            do_load = 1'b0;
            if (!m_act) begin
                if (enable) do_load = 1'b1;
            end else if (m_t == 255 * (m_p + 1) - 1) begin
                if (enable) do_load = 1'b1;
                else begin
                    m_act = 1'b0;
                    m_t   = 0;
                end
            end else begin
                m_t++;
            end
            e_ps = do_load;
            if (do_load) begin
                m_act     = 1'b1;
                m_t       = 0;
                m_p       = int'(presc);
                m_duty[0] = int'(red_in);
                m_duty[1] = int'(green_in);
                m_duty[2] = int'(blue_in);
                m_duty[3] = int'(white_in);
            end
            e_busy = m_act;
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pin_nostag_ch%0d", k), pin0[k], e_pin0[k]);
            chk($sformatf("pin_stag_ch%0d", k), pin1[k], e_pin1[k]);
        end
        chk("period_start_nostag", ps0, e_ps);
        chk("period_start_stag", ps1, e_ps);
        chk("busy_nostag", busy0, e_busy);
        chk("busy_stag", busy1, e_busy);
    end

    // Window measurements
    int         hi0 [4];
    int         hi1 [4];
    int         rise1 [4];
    logic [3:0] prev1;
    int         ps_cnt, ps_last, busy_cnt, mi;

    task automatic clear_meas();
        for (int k = 0; k < 4; k++) begin
            hi0[k]   = 0;
            hi1[k]   = 0;
            rise1[k] = -1;
        end
        prev1    = '0;
        ps_cnt   = 0;
        ps_last  = -1;
        busy_cnt = 0;
        mi       = 0;
    endtask

    task automatic sample();
        for (int k = 0; k < 4; k++) begin
            if (pin0[k]) hi0[k]++;
            if (pin1[k]) begin
                hi1[k]++;
                if (!prev1[k] && rise1[k] < 0) rise1[k] = mi;
            end
        end
        prev1 = pin1;
        if (ps0) begin
            ps_cnt++;
            ps_last = mi;
        end
        if (busy0) busy_cnt++;
        mi++;
    endtask

    task automatic measure(input int n, input bit now);
        for (int i = 0; i < n; i++) begin
            if (!(now && i == 0)) @(negedge clk);
            sample();
        end
    endtask

    task automatic wait_ps(input int budget, input string nm);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (ps0) found = 1'b1;
        end
        chk(nm, found, 1);
    endtask

    task automatic at_edge();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] pick_duty();
        int unsigned r = $urandom_range(0, 9);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_period_start", ps0, 0);
        chk("rst_pins", int'(pin0) + int'(pin1), 0);
        at_edge();
        reset = 1'b1;
        at_edge();

        // Basic duty, always-off and always-on channels
        presc    = 8'd0;
        red_in   = 8'd128;
        green_in = pick_duty();
        blue_in  = 8'd0;
        white_in = 8'd255;
        enable   = 1'b1;
        wait_ps(5, "ps_on_enable");
        clear_meas();
        measure(765, 1'b1);
        chk("red128_high_3per", hi0[0], 384);
        chk("blue0_high_nostag", hi0[2], 0);
        chk("blue0_high_stag", hi1[2], 0);
        chk("white255_high_nostag", hi0[3], 764);
        chk("white255_high_stag", hi1[3], 764);
        chk("ps_count_3per", ps_cnt, 3);
        chk("ps_last_3per", ps_last, 510);
        chk("red_first_rise", rise1[0], 1);

        // Prescaler 3 with a mid-period duty change
        at_edge();
        presc    = 8'd3;
        green_in = 8'd40;
        repeat (2) @(negedge clk);
        wait_ps(1100, "ps_presc3");
        clear_meas();
        measure(500, 1'b1);
        at_edge();
        green_in = 8'd200;
        measure(520, 1'b0);
        chk("green40_presc3_high", hi0[1], 160);
        chk("ps_count_presc3_p1", ps_cnt, 1);
        clear_meas();
        measure(1021, 1'b0);
        chk("green200_presc3_high", hi0[1], 800);
        chk("ps_count_presc3_p2", ps_cnt, 2);
        chk("period_len_presc3", ps_last, 1020);

        // Drop enable at cnt 100: finish the period, then idle
        at_edge();
        presc  = 8'd0;
        red_in = 8'd200;
        repeat (2) @(negedge clk);
        wait_ps(1100, "ps_before_stop");
        clear_meas();
        measure(100, 1'b1);
        at_edge();
        enable = 1'b0;
        clear_meas();
        measure(300, 1'b0);
        chk("stop_busy_clks", busy_cnt, 155);
        chk("stop_no_ps", ps_cnt, 0);
        chk("stop_red_continues", hi0[0], 101);
        clear_meas();
        measure(100, 1'b0);
        chk("idle_pins_nostag", hi0[0] + hi0[1] + hi0[2] + hi0[3], 0);
        chk("idle_pins_stag", hi1[0] + hi1[1] + hi1[2] + hi1[3], 0);
        chk("idle_busy", busy_cnt, 0);

        // Stagger: all duties 64
        at_edge();
        red_in   = 8'd64;
        green_in = 8'd64;
        blue_in  = 8'd64;
        white_in = 8'd64;
        enable   = 1'b1;
        wait_ps(5, "ps_reenable");
        clear_meas();
        measure(256, 1'b1);
        chk("stag_rise_red", rise1[0], 1);
        chk("stag_rise_green", rise1[1], 192);
        chk("stag_rise_blue", rise1[2], 128);
        chk("stag_rise_white", rise1[3], 64);
        for (int k = 0; k < 4; k++) chk($sformatf("stag_high_ch%0d", k), hi1[k], 64);

        // Asynchronous reset mid-period at cnt 50
        repeat (50) @(negedge clk);
        chk("pre_reset_red_high", r0, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_pins", int'(pin0) + int'(pin1), 0);
        chk("async_rst_busy", busy0, 0);
        #1;
        reset = 1'b1;
        wait_ps(5, "ps_after_reset");
        clear_meas();
        measure(256, 1'b1);
        chk("post_reset_red_rise", rise1[0], 1);
        chk("post_reset_red_high", hi0[0], 64);

        // Randomized traffic
        for (int i = 0; i < 15000; i++) begin
            at_edge();
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 2999) == 0) reset = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                red_in   = pick_duty();
                green_in = pick_duty();
                blue_in  = pick_duty();
                white_in = pick_duty();
            end
            if ($urandom_range(0, 199) == 0) presc = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) enable = ~enable;
        end
        at_edge();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgbw_pwm_generator.md
Name: rgbw_pwm_generator

Overview:
Downstream stage of the colour wheel processor. Takes its four registered 8-bit RGBW outputs and drives four LED PWM pins at 8-bit resolution. Duty values and the prescaler are shadow-latched only at period boundaries, so the processor's output updates never cause mid-period glitches. An optional per-channel phase stagger spreads the turn-on edges to limit supply inrush.

Parameters:
STAGGER_EN, 1, 1 = channel phase offsets R/G/B/W = 0/64/128/192 ticks; 0 = all offsets 0
PERIOD, 255, ticks per PWM period; fixed so duty 255 = always on and 0 = always off

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
enable  input  1  run request, level-sensitive
presc  input  8  clock divider; one tick every presc+1 clk
red_in  input  8  red duty from colour processor
green_in  input  8  green duty
blue_in  input  8  blue duty
white_in  input  8  white duty
red_pwm  output  1  red PWM pin
green_pwm  output  1  green PWM pin
blue_pwm  output  1  blue PWM pin
white_pwm  output  1  white PWM pin
period_start  output  1  one-clk pulse when a new period begins (shadows just loaded)
busy  output  1  high while in RUN or STOPPING

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all pwm outputs 0; period_start 0; busy 0; prescaler, tick counter and shadows cleared. Reset asserted mid-period forces outputs low immediately, with no clock needed.
- Prescaler: pcnt counts 0..presc_sh; tick=1 for one clk when pcnt==presc_sh, then pcnt returns to 0. When presc_sh=0, tick is high every clk.
- Period counter cnt: 0..254; advances on tick; wraps 254->0.
- States:
  - IDLE: outputs 0, counters held at 0. Leave to RUN when enable=1. On that edge, load shadows (4 duties and presc), set cnt=0 and pcnt=0, and pulse period_start.
  - RUN: at a tick with cnt==254, cnt->0, reload all shadows from inputs, pulse period_start on the next clk. If enable=0 at any time, go to STOPPING.
  - STOPPING: continue the current period unchanged. At the wrap tick go to IDLE without reloading shadows and without period_start. If enable returns to 1 while STOPPING, go back to RUN; the period completes normally with a reload.
- Channel compare, per channel k: pos = cnt + off_k. If pos >= 255, subtract 255; use 9-bit intermediate arithmetic with no 8-bit wrap. Condition is pos < duty_sh_k.
- pwm_k is registered: pwm_k <= (state != IDLE) && compare. One clk latency from cnt/shadow to pin.
- High time per period = duty_sh_k ticks exactly, for any offset.
- Input duties and presc may change at any clk. Only the values present on the clk of the wrap tick (or the enable edge) are used.
- period_start and busy are registered outputs.

Decomposition:
- Shared package (rgbw_pwm_pkg): PWM_PERIOD=255, channel offset constants OFF_R/G/B/W, state encoding IDLE/RUN/STOPPING (2 bits), channel index constants.
- Sub-module pwm_channel_cmp: holds the shadow duty, computes the offset-modulo position and registers the pin. Instantiated 4 times with the offset as a parameter.
- Top level holds the prescaler, period counter, FSM and shadow load strobe.

Test Plan:
- presc=0, STAGGER_EN=0, red_in=128, enable=1 -> red_pwm high exactly 128 of every 255 clk; period_start every 255 clk; first rising edge 1 clk after period_start.
- Duty 0 on blue and 255 on white over 3 periods -> blue_pwm constantly 0, white_pwm constantly 1 (after the 1-clk latency).
- presc=3, green_in changed 40->200 mid-period -> current period keeps 40*4=160 clk high; next period (after period_start) 200*4=800 clk high; period length 1020 clk.
- STAGGER_EN=1, all duties 64, presc=0 -> red rises at cnt 0, green at cnt 191, blue at 127, white at 63; each high 64 clk; no two channels rise on the same clk.
- enable dropped at cnt=100 -> outputs continue to cnt 254, then all 0; busy falls at wrap; no period_start. Re-enable -> immediate reload with period_start.
- reset pulled low at cnt=50 between clock edges -> all pins 0 asynchronously. After release with enable=1 -> fresh period starting at cnt 0.
